// File: rtl/midgard_mem_resp.sv
// rtl/midgard_mem_resp.sv - PTE memory responder with fixed latency and in-order FIFO
//
// Purpose: accepts PTE read requests, holds them in a QDEPTH-entry FIFO, and
// returns each one no earlier than LAT cycles after acceptance, strictly in
// request order. PTE words live in a DEPTH-entry storage array that is filled
// through a backdoor preload port and is never reset.
//
// Ports:
//   clock, reset            clock; asynchronous active-low reset
//   mem_req_o_valid/ready   request handshake (ready = FIFO not full)
//   mem_req_o_bits          PTE byte address (PA_BITS)
//   mem_resp_i_valid/ready  response handshake
//   mem_resp_i_bits_err     out-of-range (or injected) error flag
//   mem_resp_i_bits_pte     PTE data (0 on error or when not valid)
//   pre_wen/idx/data        backdoor storage write, visible the next cycle
//
// Optional feature: MIDGARD_MEM_ERR_INJ_EN -- when defined, address bit
// PA_BITS-1 forces an error response.

module midgard_mem_resp #(
  parameter int PA_BITS  = 48,
  parameter int PTE_BITS = 64,
  parameter int DEPTH    = 1024,
  parameter int LAT      = 4,
  parameter int QDEPTH   = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       mem_req_o_valid,
  output logic                       mem_req_o_ready,
  input  logic [PA_BITS-1:0]         mem_req_o_bits,
  output logic                       mem_resp_i_valid,
  input  logic                       mem_resp_i_ready,
  output logic                       mem_resp_i_bits_err,
  output logic [PTE_BITS-1:0]        mem_resp_i_bits_pte,
  input  logic                       pre_wen,
  input  logic [$clog2(DEPTH)-1:0]   pre_idx,
  input  logic [PTE_BITS-1:0]        pre_data
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int OFF_W = $clog2(PTE_BITS / 8);
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [PTE_BITS-1:0] r_mem [DEPTH];
  logic [PA_BITS-1:0]  r_addr [QDEPTH];
  logic [CNT_W-1:0]    r_cnt [QDEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W:0]      r_count;

  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_valid;
  logic [PA_BITS-1:0]  w_head_addr;
  logic [PA_BITS-1:0]  w_word;
  logic                w_err;

  // Ready is purely registered state: a pop in the same cycle does not free
  // a slot for an incoming push.
  assign w_full          = (r_count == (PTR_W + 1)'(QDEPTH));
  assign mem_req_o_ready = !w_full;
  assign w_push          = mem_req_o_valid && !w_full;
  assign w_valid         = (r_count != '0) && (r_cnt[r_rd_ptr] == '0);
  assign w_pop           = w_valid && mem_resp_i_ready;
  assign mem_resp_i_valid = w_valid;

  always_ff @(posedge clock) begin
    if (pre_wen) begin
      r_mem[pre_idx] <= pre_data;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= mem_req_o_bits;
    end
  end

  // Free slots also count down; harmless, since a push always reloads the
  // countdown of the slot it writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (w_push && (r_wr_ptr == PTR_W'(i))) begin
          r_cnt[i] <= CNT_W'(LAT - 1);
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_addr = r_addr[r_rd_ptr];
  assign w_word      = w_head_addr >> OFF_W;

`ifdef MIDGARD_MEM_ERR_INJ_EN
  assign w_err = (w_word >= PA_BITS'(DEPTH)) || w_head_addr[PA_BITS-1];
`else
  assign w_err = (w_word >= PA_BITS'(DEPTH));
`endif

  // Storage is read combinationally from the head address, so a preload
  // landing on the pop edge is not seen by that response.
  always_comb begin
    mem_resp_i_bits_err = 1'b0;
    mem_resp_i_bits_pte = '0;
    if (w_valid) begin
      if (w_err) begin
        mem_resp_i_bits_err = 1'b1;
      end else begin
        mem_resp_i_bits_pte = r_mem[w_word[IDX_W-1:0]];
      end
    end
  end

endmodule

// File: tb/tb_midgard_mem_resp.sv
// tb/tb_midgard_mem_resp.sv - scoreboard testbench for midgard_mem_resp
module tb_midgard_mem_resp;
  localparam int LAT = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [47:0] req_bits = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic        resp_err;
  logic [63:0] resp_pte;
  logic        pre_wen = 1'b0;
  logic [9:0]  pre_idx = '0;
  logic [63:0] pre_data = '0;

  midgard_mem_resp dut (
    .clock               (clock),
    .reset               (reset),
    .mem_req_o_valid     (req_valid),
    .mem_req_o_ready     (req_ready),
    .mem_req_o_bits      (req_bits),
    .mem_resp_i_valid    (resp_valid),
    .mem_resp_i_ready    (resp_ready),
    .mem_resp_i_bits_err (resp_err),
    .mem_resp_i_bits_pte (resp_pte),
    .pre_wen             (pre_wen),
    .pre_idx             (pre_idx),
    .pre_data            (pre_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        err;
    logic [63:0] pte;
    int          mincyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_pops = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops the scoreboard on every response handshake.
  always @(negedge clock) begin
    if (reset) begin
      if (resp_valid) begin
        chk("resp_expected", 64'(sb.size() > 0), 64'd1);
        if (resp_ready && sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          n_pops++;
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("resp_pte", resp_pte, e.pte);
          chk("resp_not_early", 64'(cyc >= e.mincyc), 64'd1);
        end
      end else begin
        chk("idle_payload_zero", {resp_pte[62:0], resp_err}, 64'd0);
      end
    end
  end

  task automatic preload(input logic [9:0] idx, input logic [63:0] data);
    pre_wen = 1'b1; pre_idx = idx; pre_data = data;
    @(posedge clock); #1;
    pre_wen = 1'b0;
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send(input logic [47:0] addr, input logic err, input logic [63:0] pte);
    bit done = 0;
    req_valid = 1'b1; req_bits = addr;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clock);
      if (req_ready) begin
        sb.push_back('{err: err, pte: pte, mincyc: cyc + LAT});
        done = 1;
      end
      @(posedge clock); #1;
    end
    if (!done) chk("send_accepted", 64'd0, 64'd1);
    req_valid = 1'b0;
  endtask

  task automatic timed_req(input logic [47:0] addr, input logic err, input logic [63:0] pte);
    resp_ready = 1'b1;
    send(addr, err, pte);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clock);
      chk("latency_valid", 64'(resp_valid), 64'(k == LAT));
    end
    @(negedge clock);
    chk("single_cycle_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); #1;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 20 && !resp_valid; k++) @(negedge clock);
    chk("wait_valid", 64'(resp_valid), 64'd1);
    @(posedge clock); #1;
  endtask

  logic [63:0] tab [4] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                           64'h0000_0000_0000_0001, 64'h8000_0000_0000_0000};

  initial begin
    int p0;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 4; i++) preload(10'(i), tab[i]);
    preload(10'd5, 64'hDEAD_BEEF);
    preload(10'd6, 64'h0000_AAAA);
    preload(10'd1023, 64'h00C0_FFEE);

    timed_req(48'h28, 1'b0, 64'hDEAD_BEEF);
    timed_req(48'h2F, 1'b0, 64'hDEAD_BEEF);
    timed_req(48'h2000, 1'b1, 64'd0);
    timed_req(48'h1FF8, 1'b0, 64'h00C0_FFEE);
    timed_req(48'h8000_0000_0000, 1'b1, 64'd0);

    // Fill the FIFO with the consumer stalled.
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(48'(i * 8), 1'b0, tab[i]);
    req_valid = 1'b1; req_bits = 48'h28;
    repeat (LAT) begin
      @(negedge clock);
      chk("full_no_accept", 64'(req_ready), 64'd0);
    end
    @(posedge clock); #1;
    resp_ready = 1'b1;
    p0 = n_pops;
    @(negedge clock);
    chk("push_rejected_on_pop", 64'(req_ready), 64'd0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("push_after_pop", 64'(req_ready), 64'd1);
    if (req_ready) sb.push_back('{err: 1'b0, pte: 64'hDEAD_BEEF, mincyc: cyc + LAT});
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(negedge clock); @(negedge clock);
    @(posedge clock); #1;
    chk("back_to_back_pops", 64'(n_pops - p0), 64'd4);
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clock);
    #1;

    // A preload on the pop edge must not affect that response.
    resp_ready = 1'b0;
    send(48'h30, 1'b0, 64'h0000_AAAA);
    wait_valid();
    pre_wen = 1'b1; pre_idx = 10'd6; pre_data = 64'h0000_5555;
    resp_ready = 1'b1;
    @(posedge clock); #1;
    pre_wen = 1'b0;
    timed_req(48'h30, 1'b0, 64'h0000_5555);

    // Reset with two requests outstanding.
    resp_ready = 1'b0;
    send(48'h0, 1'b0, tab[0]);
    send(48'h8, 1'b0, tab[1]);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_ready", 64'(req_ready), 64'd1);
    chk("async_reset_valid", 64'(resp_valid), 64'd0);
    repeat (2) begin
      @(negedge clock);
      chk("in_reset_ready", 64'(req_ready), 64'd1);
      chk("in_reset_valid", 64'(resp_valid), 64'd0);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    resp_ready = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    timed_req(48'h28, 1'b0, 64'hDEAD_BEEF);

    for (int k = 0; k < 50 && sb.size() > 0; k++) @(posedge clock);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end
endmodule

// File: doc/midgard_mem_resp.md
MIDGARD_MEM_RESP -- requirements
Module: midgard_mem_resp

Interface
REQ-001 SHALL have parameter PA_BITS, default 48, physical address width of mem_req bits.
REQ-002 SHALL have parameter PTE_BITS, default 64, PTE data width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of PTE words in storage (power of 2).
REQ-004 SHALL have parameter LAT, default 4, request-to-response latency in cycles (LAT >= 1).
REQ-005 SHALL have parameter QDEPTH, default 4, outstanding request capacity (power of 2).
REQ-006 SHALL have port clock, input, 1, clock.
REQ-007 SHALL have port reset, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have ports mem_req_o_valid input 1 and mem_req_o_ready output 1; together these are the request handshake.
REQ-009 SHALL have port mem_req_o_bits, input, PA_BITS, byte address of the PTE.
REQ-010 SHALL have ports mem_resp_i_valid output 1 and mem_resp_i_ready input 1; together these are the response handshake.
REQ-011 SHALL have ports mem_resp_i_bits_err output 1 and mem_resp_i_bits_pte output PTE_BITS; these carry the response payload.
REQ-012 SHALL have ports pre_wen input 1, pre_idx input log2(DEPTH) and pre_data input PTE_BITS; together these form the backdoor preload write port.

Function
REQ-013 A request SHALL be accepted on a cycle with mem_req_o_valid && mem_req_o_ready.
REQ-014 mem_req_o_ready SHALL equal !full; no same-cycle bypass when full, even if a pop occurs.
REQ-015 Each accepted request SHALL enter a FIFO slot with an address and a countdown loaded with LAT-1.
REQ-016 Every occupied slot's countdown SHALL decrement each cycle, saturating at 0.
REQ-017 mem_resp_i_valid SHALL be 1 iff the FIFO is non-empty and the head countdown == 0, giving a minimum latency of exactly LAT cycles from acceptance to valid.
REQ-018 Once asserted, mem_resp_i_valid and the payload SHALL hold stable until mem_resp_i_ready; pop occurs on valid && ready.
REQ-019 Word index SHALL be addr >> log2(PTE_BITS/8); if index >= DEPTH, then err=1 and pte=0; otherwise err=0 and pte=storage[index].
REQ-020 Storage read SHALL be combinational at response time; a preload write SHALL take effect the cycle after pre_wen, so a same-cycle response sees old data.
REQ-021 Responses SHALL be returned strictly in request order.
REQ-022 Simultaneous push and pop with 0 < count < QDEPTH SHALL leave count unchanged; pointers SHALL wrap modulo QDEPTH.
REQ-023 Payload outputs SHALL be 0 whenever mem_resp_i_valid is 0.

Reset
REQ-024 On reset low, the FIFO pointers, count and countdowns SHALL clear asynchronously; mem_req_o_ready=1 and mem_resp_i_valid=0 SHALL hold from the first reset cycle.
REQ-025 Storage contents SHALL NOT be reset; preloaded data survives reset.
REQ-026 Reset mid-transaction SHALL discard all outstanding requests without emitting responses.

Configuration
REQ-027 Macro MIDGARD_MEM_ERR_INJ_EN: when defined, a request with address bit PA_BITS-1 set SHALL return err=1 and pte=0 regardless of index.
REQ-028 Without MIDGARD_MEM_ERR_INJ_EN, bit PA_BITS-1 SHALL be treated as an ordinary address bit.

Verification
REQ-029 Preload idx 5 = 0xDEAD_BEEF, request addr 0x28 at cycle t, resp_ready=1 -> valid at t+4, err=0, pte=0xDEAD_BEEF, single cycle.
REQ-030 Four back-to-back requests to idx 0..3 with resp_ready=0 -> req_ready=0 after the 4th; the 5th is not accepted; raising resp_ready yields idx 0..3 in order, one per cycle.
REQ-031 Request addr 0x2000 (idx 1024, DEPTH=1024) -> err=1, pte=0 after 4 cycles.
REQ-032 With the macro defined, PA_BITS=48, request addr 1<<47 -> err=1; without the macro, the same address -> err=1 via the out-of-range rule, while addr (1<<47) is distinguishable only with DEPTH covering it.
REQ-033 Two requests outstanding, reset asserted for 2 cycles -> no response ever appears; req_ready=1 and the next request responds after LAT cycles.
REQ-034 Full FIFO, resp_ready=1 and req_valid=1 on the same cycle -> pop occurs, push is rejected, and the push is accepted on the next cycle.
